// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP/OP-IMM/LUI/AUIPC decode into ALU op and operands behind a 2-entry skid buffer
module alu_issue_stage #(
    parameter int NBIT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [NBIT-1:0] in_pc,
    input  logic [NBIT-1:0] in_rs1_data,
    input  logic [NBIT-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_op,
    output logic [NBIT-1:0] out_a,
    output logic [NBIT-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);
    typedef enum logic [3:0] {
        NOP = 4'd0, AND = 4'd1, OR = 4'd2, XOR = 4'd3, SLT = 4'd4,
        SLTU = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8, ADD = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t         op;
        logic [NBIT-1:0] a;
        logic [NBIT-1:0] b;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } entry_t;

    // bit 1 is out_valid and bit 0 is in_ready, so both handshake outputs come straight from flops
    typedef enum logic [1:0] {EMPTY = 2'b01, BUSY = 2'b11, FULL = 2'b10} state_t;

    state_t     state, next;
    entry_t     main_q, skid_q, dec;
    logic [1:0] rst_sync;
    logic       rst_int_n, accept, drain;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       is_op, is_imm, is_lui, is_auipc, shift, alt, f7_ok, legal;
    alu_op_t    alu_op;

    // async-assert, sync-release reset used by all internal state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= 2'b00;
        else rst_sync <= {rst_sync[0], 1'b1};

    assign rst_int_n = rst_sync[1];
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // combinational decode of the incoming instruction into an issue entry
    always_comb begin
        opcode   = in_instr[6:0];
        f3       = in_instr[14:12];
        f7       = in_instr[31:25];
        is_op    = opcode == 7'b0110011;
        is_imm   = opcode == 7'b0010011;
        is_lui   = opcode == 7'b0110111;
        is_auipc = opcode == 7'b0010111;
        shift    = f3 == 3'd1 || f3 == 3'd5;
        alt      = f7 == 7'b0100000;
        f7_ok    = f7 == 7'b0000000 || (alt && (f3 == 3'd5 || (is_op && f3 == 3'd0)));
        legal    = (is_op && f7_ok) || (is_imm && (!shift || f7_ok)) || is_lui || is_auipc;
        alu_op   = f3 == 3'd0 ? ADD : f3 == 3'd1 ? SLL : f3 == 3'd2 ? SLT : f3 == 3'd3 ? SLTU :
                   f3 == 3'd4 ? XOR : f3 == 3'd5 ? (f7[5] ? SRA : SRL) : f3 == 3'd6 ? OR : AND;
        dec.op   = !legal ? NOP : (is_lui || is_auipc) ? ADD : alu_op;
        dec.a    = (!legal || is_lui) ? '0 : is_auipc ? in_pc : in_rs1_data;
        dec.b    = !legal ? '0 :
                   (is_lui || is_auipc) ? NBIT'($signed({in_instr[31:12], 12'b0})) :
                   shift ? (is_op ? NBIT'(in_rs2_data[4:0]) : NBIT'(in_instr[24:20])) :
                   is_op ? ((f3 == 3'd0 && alt) ? -in_rs2_data : in_rs2_data) :
                   NBIT'($signed(in_instr[31:20]));
        dec.rd      = in_instr[11:7];
        dec.illegal = !legal;
        dec.we      = legal && in_instr[11:7] != 5'd0;
    end

    // skid buffer state register
    always_ff @(posedge clk or negedge rst_int_n)
        if (!rst_int_n) state <= EMPTY;
        else state <= next;

    // skid buffer next state
    always_comb begin
        next = state == EMPTY ? (accept ? BUSY : EMPTY) :
               state == BUSY  ? ((accept && !drain) ? FULL : (!accept && drain) ? EMPTY : BUSY) :
               state == FULL  ? (drain ? BUSY : FULL) : EMPTY;
    end

    // main register feeds the outputs; skid register catches the item that arrives while main is stalled
    always_ff @(posedge clk or negedge rst_int_n)
        if (!rst_int_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (state == FULL ? drain : (accept && (state == EMPTY || drain)))
                main_q <= state == FULL ? skid_q : dec;
            if (state == BUSY && accept && !drain)
                skid_q <= dec;
        end

    // outputs taken directly from state bits and the main register
    always_comb begin
        in_ready    = state[0];
        out_valid   = state[1];
        out_op      = main_q.op;
        out_a       = main_q.a;
        out_b       = main_q.b;
        out_rd      = main_q.rd;
        out_we      = main_q.we;
        out_illegal = main_q.illegal;
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a queue-based reference model
module tb_alu_issue_stage;
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = 0, in_pc = 0, in_rs1_data = 0, in_rs2_data = 0;
    logic        in_ready, out_valid, out_we, out_illegal;
    logic [3:0]  out_op;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;

    int   total = 0, bad = 0;
    exp_t q[$];
    exp_t none = '0;

    logic [31:0] d_ins [7] = '{32'h002081B3, 32'h402080B3, 32'h40435293, 32'h12345397,
                               32'h00000013, 32'h0000007F, 32'h402080B3};
    logic [31:0] d_pc  [7] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0};
    logic [31:0] d_r1  [7] = '{32'd5, 32'd3, 32'hF0000000, 32'h0, 32'h0, 32'h0, 32'd9};
    logic [31:0] d_r2  [7] = '{32'd7, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000};
    exp_t        d_exp [7] = '{'{4'd9, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0},
                               '{4'd9, 32'd3, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0},
                               '{4'd8, 32'hF0000000, 32'd4, 5'd5, 1'b1, 1'b0},
                               '{4'd9, 32'h100, 32'h12345000, 5'd7, 1'b1, 1'b0},
                               '{4'd9, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0},
                               '{4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1},
                               '{4'd9, 32'd9, 32'h80000000, 5'd1, 1'b1, 1'b0}};

    always #5 clk = ~clk;

    alu_issue_stage #(.NBIT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_a(out_a),
        .out_b(out_b), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, pc, r1, r2);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] bv;
        logic [3:0]  op;
        logic        ok, rf;
        e = '0;
        e.rd = ins[11:7];
        e.ill = 1'b1;
        f3 = ins[14:12];
        f7 = ins[31:25];
        if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
            e.ill = 1'b0;
            e.op = 4'd9;
            e.a = ins[6:0] == 7'h17 ? pc : 32'd0;
            e.b = ins & 32'hFFFFF000;
        end else if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
            rf = ins[6:0] == 7'h33;
            bv = rf ? r2 : {{20{ins[31]}}, ins[31:20]};
            ok = !rf || f7 == 7'h00;
            op = 4'd0;
            case (f3)
                3'd0: begin
                    op = 4'd9;
                    ok = !rf || f7 == 7'h00 || f7 == 7'h20;
                    if (rf && f7 == 7'h20) bv = 32'd0 - r2;
                end
                3'd1: begin op = 4'd6; ok = f7 == 7'h00; bv = bv % 32; end
                3'd2: op = 4'd4;
                3'd3: op = 4'd5;
                3'd4: op = 4'd3;
                3'd5: begin
                    op = f7 == 7'h20 ? 4'd8 : 4'd7;
                    ok = f7 == 7'h00 || f7 == 7'h20;
                    bv = bv % 32;
                end
                3'd6: op = 4'd2;
                default: op = 4'd1;
            endcase
            if (ok) begin
                e.ill = 1'b0;
                e.op = op;
                e.a = r1;
                e.b = bv;
            end
        end
        e.we = !e.ill && e.rd != 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          s, t;
        r = $urandom;
        s = $urandom_range(0, 9);
        t = $urandom_range(0, 9);
        r[6:0] = s < 4 ? 7'h33 : s < 7 ? 7'h13 : s == 7 ? 7'h37 : s == 8 ? 7'h17 : r[6:0];
        r[31:25] = t < 5 ? 7'h00 : t < 8 ? 7'h20 : r[31:25];
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, pc, r1, r2, input logic ordy,
                        input logic use_f, input exp_t fe, output logic acc, output logic drn);
        @(negedge clk);
        in_valid = v;
        in_instr = ins;
        in_pc = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() != 0);
        if (out_valid && q.size() != 0) begin
            chk("op", out_op, q[0].op);
            chk("a", out_a, q[0].a);
            chk("b", out_b, q[0].b);
            chk("rd", out_rd, q[0].rd);
            chk("we", out_we, q[0].we);
            chk("illegal", out_illegal, q[0].ill);
        end
        acc = v && in_ready;
        drn = out_valid && ordy;
        if (drn && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back(use_f ? fe : ref_decode(ins, pc, r1, r2));
    endtask

    initial begin
        logic acc, drn;
        int   sent, drained;
        logic [31:0] bp_ins [4];
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_op", out_op, 0);
        chk("rst_a", out_a, 0);
        chk("rst_b", out_b, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_we", out_we, 0);
        chk("rst_illegal", out_illegal, 0);
        rst_n = 1;
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, none, acc, drn);

        for (int i = 0; i < 7; i++) begin
            step(1, d_ins[i], d_pc[i], d_r1[i], d_r2[i], 1, 1, d_exp[i], acc, drn);
            chk("dir_accept", acc, 1);
        end
        repeat (2) step(0, 0, 0, 0, 0, 1, 0, none, acc, drn);

        bp_ins[0] = 32'h002081B3;
        bp_ins[1] = 32'h40435293;
        bp_ins[2] = 32'h12345397;
        bp_ins[3] = 32'h0000007F;
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            step(1, bp_ins[sent & 3], $urandom, $urandom, $urandom, 0, 0, none, acc, drn);
            if (acc) sent++;
        end
        chk("bp_accepted", sent, 2);
        chk("bp_in_ready", in_ready, 0);
        drained = 0;
        for (int c = 0; c < 4; c++) begin
            step(sent < 4, bp_ins[sent & 3], $urandom, $urandom, $urandom, 1, 0, none, acc, drn);
            if (acc) sent++;
            if (drn) drained++;
        end
        chk("bp_drained", drained, 4);
        chk("bp_sent", sent, 4);

        step(1, 32'h002081B3, 0, 1, 2, 0, 0, none, acc, drn);
        step(1, 32'h00000013, 0, 3, 4, 0, 0, none, acc, drn);
        step(0, 0, 0, 0, 0, 0, 0, none, acc, drn);
        chk("full_q", q.size(), 2);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        in_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, none, acc, drn);

        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) < 7, 0, none, acc, drn);
        repeat (4) step(0, 0, 0, 0, 0, 1, 0, none, acc, drn);
        chk("final_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
